// File: rtl/video_core_pattern_gen.sv
// Test-pattern pixel source: streams H_DISPLAY x V_DISPLAY pixels in raster order.
// Latency: first pixel valid one cycle after a load is allowed; one pixel/cycle sustained.
// Backpressure: src_* outputs are held stable while src_vld & ~src_rdy; no pixel dropped or repeated.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enable         permits loading of new pixels into the output register
//   mode           pattern select (0 bars, 1 checker, 2 solid, 3 border), latched at frame start
//   solid_rgb      colour for mode 2, latched at frame start
//   src_vld/rdy    output valid/ready handshake
//   src_fc         pixel coordinates (x = column, y = row)
//   src_rgb        pixel colour, R in MSBs, then G, then B
//   src_sof        marks pixel (0,0)

typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
} vga_fc_t;

module video_core_pattern_gen #(
    parameter int RGB_SIZE  = 12,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int BORDER_W  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [RGB_SIZE-1:0] solid_rgb,
    output logic                src_vld,
    input  logic                src_rdy,
    output vga_fc_t             src_fc,
    output logic [RGB_SIZE-1:0] src_rgb,
    output logic                src_sof
);

    localparam int          C        = RGB_SIZE / 3;
    localparam logic [11:0] X_LAST   = 12'(H_DISPLAY - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_DISPLAY - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_DISPLAY / 8 - 1);
    localparam logic [11:0] BW       = 12'(BORDER_W);
    localparam logic [11:0] X_BR     = 12'(H_DISPLAY - BORDER_W);
    localparam logic [11:0] Y_BR     = 12'(V_DISPLAY - BORDER_W);

    // Position of the next pixel to be loaded into the output register.
    logic [11:0]         x;
    logic [11:0]         y;
    // Bar position tracked incrementally alongside x so no divider is needed.
    logic [11:0]         bar_px;
    logic [2:0]          bar_idx;
    logic [1:0]          mode_q;
    logic [RGB_SIZE-1:0] solid_q;

    logic                fire;
    logic                load;
    logic                first;
    logic                x_wrap;
    logic [1:0]          cur_mode;
    logic [RGB_SIZE-1:0] cur_solid;
    logic [2:0]          rgb_on;
    logic [RGB_SIZE-1:0] pix_rgb;

    assign fire   = src_vld & src_rdy;
    assign load   = enable & (~src_vld | fire);
    assign first  = (x == 12'd0) && (y == 12'd0);
    assign x_wrap = (x == X_LAST);

    // Pixel (0,0) already belongs to the new frame, so it uses the live
    // inputs that are being latched in the same cycle.
    assign cur_mode  = first ? mode      : mode_q;
    assign cur_solid = first ? solid_rgb : solid_q;

    always_comb begin
        rgb_on  = 3'b000;
        pix_rgb = '0;
        case (cur_mode)
            2'd0: begin
                // Bar order white..black is the binary count of the
                // inverted {G, R, B} enables.
                rgb_on = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
            end
            2'd1: begin
                rgb_on = {3{x[5] ^ y[5]}};
            end
            2'd3: begin
                rgb_on = {3{(x < BW) || (x >= X_BR) || (y < BW) || (y >= Y_BR)}};
            end
            default: begin
                rgb_on = 3'b000;
            end
        endcase
        if (cur_mode == 2'd2) begin
            pix_rgb = cur_solid;
        end else begin
            pix_rgb = {{C{rgb_on[2]}}, {C{rgb_on[1]}}, {C{rgb_on[0]}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_vld <= 1'b0;
            src_sof <= 1'b0;
            src_fc  <= '0;
            src_rgb <= '0;
            x       <= '0;
            y       <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
            mode_q  <= '0;
            solid_q <= '0;
        end else if (load) begin
            src_vld   <= 1'b1;
            src_fc.x  <= x;
            src_fc.y  <= y;
            src_rgb   <= pix_rgb;
            src_sof   <= first;
            if (first) begin
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end
            if (x_wrap) begin
                x       <= '0;
                bar_px  <= '0;
                bar_idx <= '0;
                y       <= (y == Y_LAST) ? 12'd0 : y + 12'd1;
            end else begin
                x <= x + 12'd1;
                if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 12'd1;
                end
            end
        end else if (fire) begin
            src_vld <= 1'b0;
        end
    end

endmodule

// File: doc/video_core_pattern_gen.md
# video_core_pattern_gen

Test-pattern pixel source for the video core. It streams one frame of H_DISPLAY x V_DISPLAY pixels in raster order over a valid/ready interface, with frame coordinates (vga_fc_t) and RGB per pixel. It sits directly upstream of the video core pipeline stage and drives that stage's pipe_in_* inputs. Four patterns are selectable per frame.

## Interface
- RGB_SIZE, 12: pixel width; split into equal R (MSBs), G, B fields of C = RGB_SIZE/3 bits.
- H_DISPLAY, 640: active pixels per line; must be a multiple of 8.
- V_DISPLAY, 480: active lines per frame.
- BORDER_W, 1: border thickness in pixels (mode 3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows generation of new pixels.
- mode  in  2  pattern select; sampled at frame start.
- solid_rgb  in  RGB_SIZE  colour for mode 2; sampled at frame start.
- src_vld  out  1  output pixel valid.
- src_rdy  in  1  downstream ready.
- src_fc  out  vga_fc_t  pixel coordinates: fc.x = column, fc.y = row.
- src_rgb  out  RGB_SIZE  pixel colour.
- src_sof  out  1  qualifies src_vld; high for pixel (0,0).

## Operation
- Registered output stage. fire = src_vld & src_rdy.
- Position counters x (0..H_DISPLAY-1) and y (0..V_DISPLAY-1) point at the next pixel to be loaded.
- Load condition: enable & (~src_vld | fire). On load:
  - src_fc, src_rgb and src_sof take the values for (x, y).
  - src_vld <= 1.
  - x increments. At H_DISPLAY-1, x wraps to 0 and y increments. At V_DISPLAY-1, y wraps to 0.
- If fire occurs and there is no load (enable low), src_vld <= 0.
- Hold rule: while src_vld & ~src_rdy, all src_* outputs are held stable, independent of enable, mode and solid_rgb.
- Frame latch: when a load happens at (x, y) = (0, 0), mode and solid_rgb are captured into mode_q and solid_q. The pattern for the whole frame uses mode_q and solid_q.
- Patterns. FULL = all C bits set in a field.
  - Mode 0, colour bars: 8 bars, each H_DISPLAY/8 wide, ordered left to right: white, yellow, cyan, green, magenta, red, blue, black.
    - Bar index comes from a bar counter and an in-bar pixel counter that advance with x. No divider is used.
    - Both counters reset to 0 when x wraps.
  - Mode 1, checkerboard: white if fc.x[5] ^ fc.y[5], else black (32x32 squares).
  - Mode 2, solid: solid_q.
  - Mode 3, border: white if x < BORDER_W, x >= H_DISPLAY-BORDER_W, y < BORDER_W or y >= V_DISPLAY-BORDER_W; black otherwise.
- Disabling: when enable drops, generation pauses after the currently held pixel fires. Position is retained, and generation resumes at the next pixel when enable rises. There is no frame restart.

## Timing
- Reset values:
  - src_vld = 0, src_sof = 0, src_fc = (0, 0), src_rgb = 0.
  - x = y = 0, bar counters = 0, mode_q = 0, solid_q = 0.
- Latency: with enable high in the first cycle after reset release, src_vld = 1 at the next edge, showing pixel (0,0).
- Throughput: one pixel per cycle while src_rdy = 1 and enable = 1. One frame is H_DISPLAY*V_DISPLAY fires.
- Stall: src_rdy low for N cycles costs exactly N cycles. No pixel is dropped or duplicated.
- Simultaneous fire and load: the output is replaced with the next pixel in the same cycle. src_vld stays 1.
- Wrap: the fire of (H_DISPLAY-1, V_DISPLAY-1) is immediately followed by (0, 0) with src_sof = 1, using the newly sampled mode.
- A mode change mid-frame has no effect until the next (0, 0) load.
- Reset mid-frame: all state returns to reset values at the next edge. The next frame starts at (0, 0).

## Test plan
- Reset, enable = 1, src_rdy = 1, mode = 0, H_DISPLAY = 640:
  - First src_vld is 1 cycle after reset release, with fc = (0,0), sof = 1, rgb = 0xFFF.
  - Pixel x = 80 has rgb 0xFF0. Pixel x = 639 has rgb 0x000.
  - Exactly 307200 fires per frame, then (0,0) again.
- Random src_rdy backpressure (50%):
  - Outputs are stable whenever vld & ~rdy.
  - Fired coordinate sequence is strictly raster with no gaps or repeats across 2 frames.
- mode = 1:
  - Pixel (32,0) = 0xFFF, (32,32) = 0x000, (0,0) = 0x000.
- mode switched 0 -> 2 (solid_rgb = 0x0A5) mid-frame:
  - The rest of the current frame stays colour bars.
  - The next frame is all 0x0A5.
  - solid_rgb changed mid-frame is ignored.
- enable low while src_vld = 1 and src_rdy = 0:
  - The pixel holds.
  - Once it fires, src_vld = 0.
  - After enable is re-raised, the next pixel is the successor coordinate.
- mode = 3, BORDER_W = 2:
  - (1,100) = 0xFFF, (2,100) = 0x000, (638,5) = 0xFFF, (10,478) = 0xFFF.
  - Assert rst mid-frame: the next valid pixel is (0,0) with sof = 1.
